// File: rtl/rgb_to_yuv_pkg.sv
// Shared constants for the RGB to YCbCr converter: latency, mode encodings,
// the Q10 coefficient table and the 8-bit offset/clamp limits.
package rgb_to_yuv_pkg;

   localparam int LAT           = 4;
   localparam int COEF_FRAC_REF = 10;

   typedef enum logic [1:0] {
      MODE_601_LIM  = 2'd0,
      MODE_601_FULL = 2'd1,
      MODE_709_LIM  = 2'd2,
      MODE_709_FULL = 2'd3
   } csc_mode_e;

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } sync_t;

   // Row per mode, columns are Y(r,g,b), Cb(r,g,b), Cr(r,g,b) in Q10
   localparam int COEF_TAB [4][9] = '{
      '{263, 516, 100, -152, -298, 450, 450, -377, -73},
      '{306, 601, 117, -173, -339, 512, 512, -429, -83},
      '{187, 629,  63, -103, -347, 450, 450, -409, -41},
      '{218, 732,  74, -117, -395, 512, 512, -465, -47}
   };

   localparam int Y_OFS_LIM = 16;
   localparam int C_OFS     = 128;
   localparam int Y_MIN_LIM = 16;
   localparam int Y_MAX_LIM = 235;
   localparam int C_MIN_LIM = 16;
   localparam int C_MAX_LIM = 240;

   function automatic int coefScaled(input logic [1:0] mode, input int idx, input int frac);
      int v;
      v = COEF_TAB[mode][idx];
      if (frac >= COEF_FRAC_REF) return v <<< (frac - COEF_FRAC_REF);
      return v >>> (COEF_FRAC_REF - frac);
   endfunction

   function automatic logic isLimited(input logic [1:0] mode);
      return (mode == MODE_601_LIM) || (mode == MODE_709_LIM);
   endfunction

   function automatic int scale8(input int v, input int bpc);
      return v <<< (bpc - 8);
   endfunction

endpackage

// File: rtl/rgb_to_yuv_csc_px.sv
// Single-pixel datapath: products, signed sums, then rounding and offset.
// Output is the unclamped signed result; the mode rides along with the data.
module rgb_to_yuv_csc_px #(
   parameter int C_BPC  = 8,
   parameter int C_FRAC = 10,
   parameter int W      = C_BPC + C_FRAC + 5
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [C_BPC-1:0]    i_r,
   input  logic [C_BPC-1:0]    i_g,
   input  logic [C_BPC-1:0]    i_b,
   input  logic [1:0]          i_mode,
   output logic signed [W-1:0] o_y,
   output logic signed [W-1:0] o_cb,
   output logic signed [W-1:0] o_cr
);
   import rgb_to_yuv_pkg::*;

   localparam logic signed [W-1:0] L_HALF = W'(2 ** (C_FRAC - 1));
   localparam logic signed [W-1:0] L_YOFS = W'(scale8(Y_OFS_LIM, C_BPC));
   localparam logic signed [W-1:0] L_COFS = W'(scale8(C_OFS, C_BPC));
   localparam logic signed [W-1:0] L_ZERO = '0;

   logic signed [W-1:0] w_comp [3];
   logic signed [W-1:0] w_coef [9];
   logic signed [W-1:0] w_prod [9];
   logic signed [W-1:0] w_yRnd, w_cbRnd, w_crRnd, w_yOfs;
   logic signed [W-1:0] r_prod [9];
   logic signed [W-1:0] r_sum  [3];
   logic signed [W-1:0] r_y, r_cb, r_cr;
   logic                r_lim1, r_lim2;

   always_comb begin
      w_comp[0] = W'(i_r);
      w_comp[1] = W'(i_g);
      w_comp[2] = W'(i_b);
      for (int i = 0; i < 9; i++) begin
         w_coef[i] = W'(coefScaled(i_mode, i, C_FRAC));
         w_prod[i] = w_comp[i % 3] * w_coef[i];
      end
   end

   // Floor shift after adding half an LSB gives round-half-up
   always_comb begin
      w_yRnd  = (r_sum[0] + L_HALF) >>> C_FRAC;
      w_cbRnd = (r_sum[1] + L_HALF) >>> C_FRAC;
      w_crRnd = (r_sum[2] + L_HALF) >>> C_FRAC;
      w_yOfs  = r_lim2 ? L_YOFS : L_ZERO;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < 9; i++) r_prod[i] <= '0;
         for (int c = 0; c < 3; c++) r_sum[c] <= '0;
         r_lim1 <= 1'b0;
         r_lim2 <= 1'b0;
         r_y    <= '0;
         r_cb   <= '0;
         r_cr   <= '0;
      end else begin
         for (int i = 0; i < 9; i++) r_prod[i] <= w_prod[i];
         r_lim1 <= isLimited(i_mode);
         for (int c = 0; c < 3; c++) r_sum[c] <= r_prod[3*c] + r_prod[3*c+1] + r_prod[3*c+2];
         r_lim2 <= r_lim1;
         r_y    <= w_yRnd + w_yOfs;
         r_cb   <= w_cbRnd + L_COFS;
         r_cr   <= w_crRnd + L_COFS;
      end
   end

   assign o_y  = r_y;
   assign o_cb = r_cb;
   assign o_cr = r_cr;

endmodule

// File: rtl/rgb_to_yuv_csc.sv
// Multi-pixel RGB to YCbCr converter with frame-synchronous mode/format
// shadows, clamping, optional 4:2:2 chroma decimation and matched sync delay.
module rgb_to_yuv_csc #(
   parameter int C_BPC      = 8,
   parameter int C_PORT_NUM = 4,
   parameter int C_FRAC     = 10
) (
   input  logic                          CLK_I,
   input  logic                          RST_I,
   input  logic                          HS_I,
   input  logic                          VS_I,
   input  logic                          DE_I,
   input  logic [C_BPC*C_PORT_NUM-1:0]   R_I,
   input  logic [C_BPC*C_PORT_NUM-1:0]   G_I,
   input  logic [C_BPC*C_PORT_NUM-1:0]   B_I,
   input  logic [1:0]                    MODE_I,
   input  logic                          FMT422_I,
   output logic [C_BPC*C_PORT_NUM-1:0]   Y_O,
   output logic [C_BPC*C_PORT_NUM-1:0]   U_O,
   output logic [C_BPC*C_PORT_NUM-1:0]   V_O,
   output logic                          HS_O,
   output logic                          VS_O,
   output logic                          DE_O
);
   import rgb_to_yuv_pkg::*;

   localparam int W         = C_BPC + C_FRAC + 5;
   localparam int DW        = C_BPC * C_PORT_NUM;
   localparam int PX_STAGES = LAT - 1;

   logic                r_vsPrev;
   logic [1:0]          r_shadowMode;
   logic                r_shadowFmt;
   logic                w_vsRise;
   logic [1:0]          w_mode;
   logic                w_fmt;
   sync_t               r_syncDly [LAT];
   logic [1:0]          r_modeDly [PX_STAGES];
   logic                r_fmtDly  [PX_STAGES];
   logic signed [W-1:0] w_y  [C_PORT_NUM];
   logic signed [W-1:0] w_cb [C_PORT_NUM];
   logic signed [W-1:0] w_cr [C_PORT_NUM];
   logic [C_BPC-1:0]    w_yC  [C_PORT_NUM];
   logic [C_BPC-1:0]    w_cbC [C_PORT_NUM];
   logic [C_BPC-1:0]    w_crC [C_PORT_NUM];
   int                  w_yLo, w_yHi, w_cLo, w_cHi;
   logic [DW-1:0]       w_yNext, w_uNext, w_vNext;
   logic [DW-1:0]       r_y, r_u, r_v;

   function automatic logic [C_BPC-1:0] clampTo(input logic signed [W-1:0] v, input int lo, input int hi);
      if (v < W'(lo)) return C_BPC'(lo);
      if (v > W'(hi)) return C_BPC'(hi);
      return v[C_BPC-1:0];
   endfunction

   function automatic logic [C_BPC-1:0] avg2(input logic [C_BPC-1:0] a, input logic [C_BPC-1:0] b);
      return C_BPC'(({1'b0, a} + {1'b0, b} + (C_BPC+1)'(1)) >> 1);
   endfunction

   // The rising-edge beat itself already uses the newly presented setting
   assign w_vsRise = VS_I & ~r_vsPrev;
   assign w_mode   = w_vsRise ? MODE_I   : r_shadowMode;
   assign w_fmt    = w_vsRise ? FMT422_I : r_shadowFmt;

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         r_vsPrev     <= 1'b0;
         r_shadowMode <= 2'd0;
         r_shadowFmt  <= 1'b0;
      end else begin
         r_vsPrev <= VS_I;
         if (w_vsRise) begin
            r_shadowMode <= MODE_I;
            r_shadowFmt  <= FMT422_I;
         end
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         for (int i = 0; i < LAT; i++) r_syncDly[i] <= '0;
         for (int i = 0; i < PX_STAGES; i++) begin
            r_modeDly[i] <= 2'd0;
            r_fmtDly[i]  <= 1'b0;
         end
      end else begin
         r_syncDly[0] <= {HS_I, VS_I, DE_I};
         for (int i = 1; i < LAT; i++) r_syncDly[i] <= r_syncDly[i-1];
         r_modeDly[0] <= w_mode;
         r_fmtDly[0]  <= w_fmt;
         for (int i = 1; i < PX_STAGES; i++) begin
            r_modeDly[i] <= r_modeDly[i-1];
            r_fmtDly[i]  <= r_fmtDly[i-1];
         end
      end
   end

   for (genvar p = 0; p < C_PORT_NUM; p++) begin : g_px
      rgb_to_yuv_csc_px #(
         .C_BPC  (C_BPC),
         .C_FRAC (C_FRAC),
         .W      (W)
      ) u_px (
         .i_clk  (CLK_I),
         .i_rst  (RST_I),
         .i_r    (R_I[p*C_BPC +: C_BPC]),
         .i_g    (G_I[p*C_BPC +: C_BPC]),
         .i_b    (B_I[p*C_BPC +: C_BPC]),
         .i_mode (w_mode),
         .o_y    (w_y[p]),
         .o_cb   (w_cb[p]),
         .o_cr   (w_cr[p])
      );
   end

   // Decimation averages already-clamped chroma of each even/odd port pair
   always_comb begin
      w_yLo = 0;
      w_yHi = 2 ** C_BPC - 1;
      w_cLo = 0;
      w_cHi = 2 ** C_BPC - 1;
      if (isLimited(r_modeDly[PX_STAGES-1])) begin
         w_yLo = scale8(Y_MIN_LIM, C_BPC);
         w_yHi = scale8(Y_MAX_LIM, C_BPC);
         w_cLo = scale8(C_MIN_LIM, C_BPC);
         w_cHi = scale8(C_MAX_LIM, C_BPC);
      end
      for (int p = 0; p < C_PORT_NUM; p++) begin
         w_yC[p]  = clampTo(w_y[p],  w_yLo, w_yHi);
         w_cbC[p] = clampTo(w_cb[p], w_cLo, w_cHi);
         w_crC[p] = clampTo(w_cr[p], w_cLo, w_cHi);
      end
      w_yNext = '0;
      w_uNext = '0;
      w_vNext = '0;
      if (r_syncDly[PX_STAGES-1].de) begin
         for (int p = 0; p < C_PORT_NUM; p++) w_yNext[p*C_BPC +: C_BPC] = w_yC[p];
         for (int p = 0; p < C_PORT_NUM; p += 2) begin
            if (r_fmtDly[PX_STAGES-1]) begin
               w_uNext[p*C_BPC +: C_BPC]     = avg2(w_cbC[p], w_cbC[p+1]);
               w_uNext[(p+1)*C_BPC +: C_BPC] = avg2(w_crC[p], w_crC[p+1]);
            end else begin
               w_uNext[p*C_BPC +: C_BPC]     = w_cbC[p];
               w_uNext[(p+1)*C_BPC +: C_BPC] = w_cbC[p+1];
               w_vNext[p*C_BPC +: C_BPC]     = w_crC[p];
               w_vNext[(p+1)*C_BPC +: C_BPC] = w_crC[p+1];
            end
         end
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         r_y <= '0;
         r_u <= '0;
         r_v <= '0;
      end else begin
         r_y <= w_yNext;
         r_u <= w_uNext;
         r_v <= w_vNext;
      end
   end

   assign Y_O  = r_y;
   assign U_O  = r_u;
   assign V_O  = r_v;
   assign HS_O = r_syncDly[LAT-1].hs;
   assign VS_O = r_syncDly[LAT-1].vs;
   assign DE_O = r_syncDly[LAT-1].de;

endmodule

// File: tb/tb_rgb_to_yuv_csc.sv
// Self-checking bench for rgb_to_yuv_csc: a reference model fills a scoreboard
// per driven beat, plus directed checks of known colour conversions.
module tb_rgb_to_yuv_csc;

   localparam int BPC = 8;
   localparam int PN  = 4;
   localparam int LAT = 4;

   logic        CLK_I = 1'b0;
   logic        RST_I;
   logic        HS_I, VS_I, DE_I, FMT422_I;
   logic [1:0]  MODE_I;
   logic [31:0] R_I, G_I, B_I;
   logic [31:0] Y_O, U_O, V_O;
   logic        HS_O, VS_O, DE_O;

   typedef struct packed {
      logic [31:0] y;
      logic [31:0] u;
      logic [31:0] v;
      logic        hs;
      logic        vs;
      logic        de;
   } exp_t;

   exp_t sbQ[$];
   int   testsRun    = 0;
   int   testsFailed = 0;
   bit   monEnable   = 1'b0;
   int   mShadowMode;
   bit   mShadowFmt;
   bit   mVsPrev;

   localparam int COEF [4][9] = '{
      '{263, 516, 100, -152, -298, 450, 450, -377, -73},
      '{306, 601, 117, -173, -339, 512, 512, -429, -83},
      '{187, 629,  63, -103, -347, 450, 450, -409, -41},
      '{218, 732,  74, -117, -395, 512, 512, -465, -47}
   };

   rgb_to_yuv_csc #(
      .C_BPC      (BPC),
      .C_PORT_NUM (PN),
      .C_FRAC     (10)
   ) dut (
      .CLK_I    (CLK_I),
      .RST_I    (RST_I),
      .HS_I     (HS_I),
      .VS_I     (VS_I),
      .DE_I     (DE_I),
      .R_I      (R_I),
      .G_I      (G_I),
      .B_I      (B_I),
      .MODE_I   (MODE_I),
      .FMT422_I (FMT422_I),
      .Y_O      (Y_O),
      .U_O      (U_O),
      .V_O      (V_O),
      .HS_O     (HS_O),
      .VS_O     (VS_O),
      .DE_O     (DE_O)
   );

   always #5 CLK_I = ~CLK_I;

   function automatic int clampI(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   function automatic void modelPix(input int mode, input int r, input int g, input int b,
                                    output int y, output int cb, output int cr);
      bit lim;
      int s [3];
      lim = (mode == 0) || (mode == 2);
      for (int c = 0; c < 3; c++)
         s[c] = (r * COEF[mode][3*c] + g * COEF[mode][3*c+1] + b * COEF[mode][3*c+2] + 512) >>> 10;
      y  = lim ? clampI(s[0] + 16, 16, 235) : clampI(s[0], 0, 255);
      cb = lim ? clampI(s[1] + 128, 16, 240) : clampI(s[1] + 128, 0, 255);
      cr = lim ? clampI(s[2] + 128, 16, 240) : clampI(s[2] + 128, 0, 255);
   endfunction

   task resetModel;
      sbQ.delete();
      repeat (LAT) sbQ.push_back('0);
      mShadowMode = 0;
      mShadowFmt  = 1'b0;
      mVsPrev     = 1'b0;
   endtask

   task applyStimulus(input bit hs, input bit vs, input bit de, input logic [1:0] mode,
                      input bit fmt, input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
      exp_t e;
      int   y [PN];
      int   cb [PN];
      int   cr [PN];
      if (vs && !mVsPrev) begin
         mShadowMode = int'(mode);
         mShadowFmt  = fmt;
      end
      mVsPrev = vs;
      e    = '0;
      e.hs = hs;
      e.vs = vs;
      e.de = de;
      if (de) begin
         for (int p = 0; p < PN; p++) begin
            modelPix(mShadowMode, int'(r[p*8 +: 8]), int'(g[p*8 +: 8]), int'(b[p*8 +: 8]), y[p], cb[p], cr[p]);
            e.y[p*8 +: 8] = 8'(y[p]);
         end
         for (int p = 0; p < PN; p += 2) begin
            if (mShadowFmt) begin
               e.u[p*8 +: 8]     = 8'((cb[p] + cb[p+1] + 1) >> 1);
               e.u[(p+1)*8 +: 8] = 8'((cr[p] + cr[p+1] + 1) >> 1);
            end else begin
               e.u[p*8 +: 8]     = 8'(cb[p]);
               e.u[(p+1)*8 +: 8] = 8'(cb[p+1]);
               e.v[p*8 +: 8]     = 8'(cr[p]);
               e.v[(p+1)*8 +: 8] = 8'(cr[p+1]);
            end
         end
      end
      sbQ.push_back(e);
      HS_I     = hs;
      VS_I     = vs;
      DE_I     = de;
      MODE_I   = mode;
      FMT422_I = fmt;
      R_I      = r;
      G_I      = g;
      B_I      = b;
      @(posedge CLK_I);
      #1;
   endtask

   task idleBeats(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0, '0);
   endtask

   // Scoreboard: entry popped at a negedge is the beat whose result is now on the outputs
   always @(negedge CLK_I) begin
      exp_t e;
      if (monEnable && !RST_I && sbQ.size() > LAT) begin
         e = sbQ.pop_front();
         testsRun++;
         if ({Y_O, U_O, V_O, HS_O, VS_O, DE_O} !== e) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard t=%0t got Y=%h U=%h V=%h hs/vs/de=%b%b%b exp Y=%h U=%h V=%h hs/vs/de=%b%b%b",
                     $time, Y_O, U_O, V_O, HS_O, VS_O, DE_O, e.y, e.u, e.v, e.hs, e.vs, e.de);
         end
      end
   end

   task test_reset;
      RST_I = 1'b1; HS_I = 1'b1; VS_I = 1'b1; DE_I = 1'b1;
      MODE_I = 2'd1; FMT422_I = 1'b0;
      R_I = '1; G_I = '1; B_I = '1;
      repeat (3) @(posedge CLK_I);
      #1;
      testsRun++;
      if ({Y_O, U_O, V_O, HS_O, VS_O, DE_O} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset_state got Y=%h U=%h V=%h hs/vs/de=%b%b%b exp all 0", Y_O, U_O, V_O, HS_O, VS_O, DE_O);
      end
      RST_I = 1'b0;
      resetModel();
      monEnable = 1'b1;
   endtask

   task test_full_white;
      applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, '1, '1, '1);
      idleBeats(3);
      testsRun++;
      if ({Y_O, U_O, V_O, DE_O} !== {32'hFFFFFFFF, 32'h80808080, 32'h80808080, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL full_white got Y=%h U=%h V=%h de=%b exp Y=ffffffff U=80808080 V=80808080 de=1", Y_O, U_O, V_O, DE_O);
      end
   endtask

   task test_limited;
      applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF);
      idleBeats(3);
      testsRun++;
      if ({Y_O, U_O, V_O} !== {32'h1010EBEB, 32'h80808080, 32'h80808080}) begin
         testsFailed++;
         $display("[TB] FAIL limited_wb got Y=%h U=%h V=%h exp Y=1010ebeb U=80808080 V=80808080", Y_O, U_O, V_O);
      end
   endtask

   task test_red;
      applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, '1, '0, '0);
      idleBeats(3);
      testsRun++;
      if ({Y_O, U_O, V_O} !== {32'h4C4C4C4C, 32'h55555555, 32'hFFFFFFFF}) begin
         testsFailed++;
         $display("[TB] FAIL full_red got Y=%h U=%h V=%h exp Y=4c4c4c4c U=55555555 V=ffffffff", Y_O, U_O, V_O);
      end
   endtask

   task test_mode_switch;
      applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, '1, '1, '1);
      applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 1'b0, '1, '0, '0);
      idleBeats(3);
      testsRun++;
      if (Y_O !== 32'h4C4C4C4C) begin
         testsFailed++;
         $display("[TB] FAIL switch_ignored got Y=%h exp Y=4c4c4c4c", Y_O);
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 1'b0, '1, 32'hFFFFFF00, 32'hFFFFFF00);
      applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, '1, '0, '0);
      idleBeats(2);
      testsRun++;
      if (Y_O !== 32'hFFFFFF36) begin
         testsFailed++;
         $display("[TB] FAIL switch_capture got Y=%h exp Y=ffffff36", Y_O);
      end
      idleBeats(1);
      testsRun++;
      if (Y_O !== 32'h36363636) begin
         testsFailed++;
         $display("[TB] FAIL switch_held got Y=%h exp Y=36363636", Y_O);
      end
   endtask

   task test_422;
      applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, '1, 32'hFF00FF00, 32'hFF00FF00);
      idleBeats(3);
      testsRun++;
      if ({Y_O, U_O, V_O} !== {32'hFF4CFF4C, 32'hC06BC06B, 32'h00000000}) begin
         testsFailed++;
         $display("[TB] FAIL decim_422 got Y=%h U=%h V=%h exp Y=ff4cff4c U=c06bc06b V=00000000", Y_O, U_O, V_O);
      end
   endtask

   task test_random;
      for (int i = 0; i < 120; i++)
         applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
   endtask

   task test_reset_midline;
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, $urandom, $urandom, $urandom);
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, $urandom, $urandom, $urandom);
      RST_I = 1'b1;
      #1;
      testsRun++;
      if ({Y_O, U_O, V_O, HS_O, VS_O, DE_O} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset_flush got Y=%h U=%h V=%h hs/vs/de=%b%b%b exp all 0", Y_O, U_O, V_O, HS_O, VS_O, DE_O);
      end
      @(posedge CLK_I);
      #1;
      RST_I = 1'b0;
      resetModel();
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, '1, '1, '1);
      idleBeats(2);
      testsRun++;
      if ({HS_O, DE_O} !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL reset_early_sync got hs/de=%b%b exp 00", HS_O, DE_O);
      end
      idleBeats(1);
      testsRun++;
      if ({HS_O, DE_O} !== 2'b11) begin
         testsFailed++;
         $display("[TB] FAIL reset_sync_offset got hs/de=%b%b exp 11", HS_O, DE_O);
      end
      testsRun++;
      if ({Y_O, U_O, V_O} !== {32'hEBEBEBEB, 32'h80808080, 32'h80808080}) begin
         testsFailed++;
         $display("[TB] FAIL reset_shadow_mode got Y=%h U=%h V=%h exp Y=ebebebeb U=80808080 V=80808080", Y_O, U_O, V_O);
      end
   endtask

   initial begin
      test_reset();
      test_full_white();
      test_limited();
      test_red();
      test_mode_switch();
      test_422();
      test_random();
      test_reset_midline();
      test_random();
      idleBeats(LAT + 2);
      monEnable = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/rgb_to_yuv_csc.md
Name: rgb_to_yuv_csc

Overview:
- Parametrised multi-pixel-per-clock RGB-to-YCbCr colour space converter.
- Generalises the fixed per-pixel converter with:
  - four selectable matrices: BT.601/BT.709, each with full or limited range;
  - frame-synchronous mode switching;
  - rounding and clamping;
  - optional 4:4:4 to 4:2:2 chroma decimation.
- Sits in the video pipe between timing/RGB source and YUV sinks (scaler, encoder).
- Passes HS/VS/DE through with matched latency.

Parameters:
- C_BPC, 8, bits per colour component (8..12).
- C_PORT_NUM, 4, pixels per clock; must be even (required for 4:2:2).
- C_FRAC, 10, coefficient fraction bits; coefficients are signed, C_FRAC+2 bits wide.

Ports:
- CLK_I  in  1  pixel clock
- RST_I  in  1  asynchronous, active-high reset
- HS_I  in  1  hsync
- VS_I  in  1  vsync, active-high
- DE_I  in  1  data enable
- R_I  in  C_BPC*C_PORT_NUM  red; pixel k at [k*C_BPC +: C_BPC], pixel 0 is leftmost
- G_I  in  C_BPC*C_PORT_NUM  green
- B_I  in  C_BPC*C_PORT_NUM  blue
- MODE_I  in  2  matrix: 0=601 limited, 1=601 full, 2=709 limited, 3=709 full
- FMT422_I  in  1  0 = 4:4:4 output, 1 = 4:2:2 output
- Y_O  out  C_BPC*C_PORT_NUM  luma
- U_O  out  C_BPC*C_PORT_NUM  4:4:4: Cb; 4:2:2: Cb on even pixels, Cr on odd pixels
- V_O  out  C_BPC*C_PORT_NUM  4:4:4: Cr; 4:2:2: all zero
- HS_O  out  1  HS_I delayed by LAT
- VS_O  out  1  VS_I delayed by LAT
- DE_O  out  1  DE_I delayed by LAT

Behaviour:
- Reset: all outputs 0, all pipeline registers 0, shadow mode = 0, shadow fmt = 0.
- Fixed latency LAT = 4 cycles, fully pipelined, one input beat per clock, no stall.
  - Stage 1: 9 products per pixel.
  - Stage 2: 3 signed sums.
  - Stage 3: round, shift, offset.
  - Stage 4: clamp and 4:2:2 decimation.
- Shadow registers:
  - MODE_I and FMT422_I are captured into shadows on a VS_I rising edge (VS_I=1 while registered VS_I was 0).
  - The capture beat and all following beats use the new setting.
  - At all other times MODE_I/FMT422_I changes are ignored.
  - A pixel in flight always completes with the setting it entered with: the setting travels down the pipe with the data.
- Arithmetic, with coefficients in Q(C_FRAC) (values listed for C_FRAC=10):
  - 601 full: Y 306,601,117; Cb -173,-339,512; Cr 512,-429,-83
  - 601 limited: Y 263,516,100; Cb -152,-298,450; Cr 450,-377,-73
  - 709 full: Y 218,732,74; Cb -117,-395,512; Cr 512,-465,-47
  - 709 limited: Y 187,629,63; Cb -103,-347,450; Cr 450,-409,-41
  - Rounding: sum + 2^(C_FRAC-1), then arithmetic shift right by C_FRAC (floor).
  - Offsets: Y +16 (limited) or +0 (full); Cb/Cr +128; all offsets shifted left by C_BPC-8.
  - Clamp, full range: [0, 2^C_BPC-1].
  - Clamp, limited range: Y [16, 235]<<(C_BPC-8); C [16, 240]<<(C_BPC-8).
  - Intermediates must not overflow: use at least C_BPC+C_FRAC+3 signed bits.
- 4:2:2 decimation:
  - For each port pair (2k, 2k+1): U_O[2k] = (Cb2k+Cb2k+1+1)>>1 and U_O[2k+1] = (Cr2k+Cr2k+1+1)>>1.
  - Averaging is applied after clamping; V_O = 0.
- Output gating: when DE_O=0, Y_O/U_O/V_O are 0.
- HS/VS/DE have no gating.
- Reset mid-frame: pipe flushes immediately to zeros; the next VS rising edge re-captures mode.

Decomposition:
- Package rgb_to_yuv_pkg holds:
  - LAT = 4;
  - mode encodings;
  - the 4x9 coefficient table;
  - offset and clamp constants, expressed for 8 bits and scaled by C_BPC.
- Sub-module rgb_to_yuv_csc_px: one pixel, stages 1-3, with mode as an input.
- Top level holds:
  - the generate loop over C_PORT_NUM;
  - shadow capture;
  - stage-4 clamp and 4:2:2 logic;
  - sync delay lines.

Test Plan:
- Reset, then mode 1 (601 full), pixel (255,255,255) with DE=1 -> 4 cycles later Y=255, U=128, V=128, DE_O=1.
- Mode 0 (601 limited): (255,255,255) -> Y=235, Cb=128, Cr=128; (0,0,0) -> Y=16, Cb=128, Cr=128.
- Mode 1, pure red (255,0,0) -> Y=76, Cb=85, Cr=255 (raw 256 clamped to 255).
- Set MODE_I from 1 to 3 mid-frame -> output is unchanged until the next VS_I rising edge; from the capture beat on, white gives Y=255 and red gives Y=54.
- FMT422=1, mode 1, ports 0/1 = red/white -> U_O[0]=(85+128+1)>>1=107, U_O[1]=(255+128+1)>>1=192, V_O=0.
- Assert RST_I for 1 cycle mid-line -> all outputs are 0 immediately, shadow mode = 0; HS/VS/DE resume at the correct 4-cycle offset after release.
